// File: rtl/bk_add_sched.sv
// Round-robin scheduler sharing one Brent-Kung adder slice between two requesters.
// W-bit add/sub ops are sequenced as W/CHUNK beats, LSB chunk first, carry registered between beats.

module brent_kung_adder #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] p_bit;
  logic [N-1:0] g_pre;
  logic [N-1:0] p_pre;

  // Parallel-prefix carry tree: up-sweep builds power-of-two spans, down-sweep fills the gaps.
  always_comb begin
    p_bit    = a ^ b;
    g_pre    = a & b;
    g_pre[0] = g_pre[0] | (p_bit[0] & cin);
    p_pre    = p_bit;
    for (int unsigned d = 1; d < N; d = d * 2) begin
      for (int unsigned i = 2 * d - 1; i < N; i = i + 2 * d) begin
        g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i-d]);
        p_pre[i] = p_pre[i] & p_pre[i-d];
      end
    end
    for (int unsigned d = N / 4; d >= 1; d = d / 2) begin
      for (int unsigned i = 3 * d - 1; i < N; i = i + 2 * d) begin
        g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i-d]);
        p_pre[i] = p_pre[i] & p_pre[i-d];
      end
    end
    sum  = p_bit ^ {g_pre[N-2:0], cin};
    cout = g_pre[N-1];
  end

endmodule

module bk_add_sched #(
  parameter int unsigned W     = 128,
  parameter int unsigned CHUNK = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  input  logic         req1_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output logic         busy
);

  localparam int unsigned BEATS = W / CHUNK;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (((W % CHUNK) != 0) || (BEATS < 2) ||
      !((CHUNK == 8) || (CHUNK == 16) || (CHUNK == 32) || (CHUNK == 64))) begin : g_bad_params
    $error("bk_add_sched: W must be a multiple of CHUNK, CHUNK in {8,16,32,64}, W/CHUNK >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           carry_q, carry_d;
  logic           last_grant_q, last_grant_d;
  logic           rsp_id_q, rsp_id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   rsp_sum_q, rsp_sum_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic             grant_c;
  logic [W-1:0]     sel_a, sel_b;
  logic             sel_cin, sel_sub;
  logic [CHUNK-1:0] add_a, add_b, add_sum;
  logic             add_cout;

  // Arbitration and request mux; readies only in IDLE and never during reset.
  always_comb begin
    grant_c    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = (state_q == ST_IDLE) & ~rst & req0_valid & ~grant_c;
    req1_ready = (state_q == ST_IDLE) & ~rst & req1_valid & grant_c;
    sel_a      = grant_c ? req1_a   : req0_a;
    sel_b      = grant_c ? req1_b   : req0_b;
    sel_cin    = grant_c ? req1_cin : req0_cin;
    sel_sub    = grant_c ? req1_sub : req0_sub;
  end

  always_comb begin
    add_a = CHUNK'(a_q >> (beat_q * CHUNK));
    add_b = CHUNK'(b_q >> (beat_q * CHUNK));
  end

  brent_kung_adder #(
    .N (CHUNK)
  ) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready | req1_ready) begin
          a_d          = sel_a;
          b_d          = sel_sub ? ~sel_b : sel_b;
          carry_d      = sel_sub ? 1'b1 : sel_cin;
          last_grant_d = grant_c;
          rsp_id_d     = grant_c;
          beat_d       = '0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        rsp_sum_d[beat_q*CHUNK +: CHUNK] = add_sum;
        carry_d = add_cout;
        beat_d  = beat_q + BW'(1);
        if (beat_q == BW'(BEATS - 1)) begin
          rsp_cout_d  = add_cout;
          rsp_valid_d = 1'b1;
          beat_d      = '0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_valid_q & rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bk_add_sched.sv
// Bench for bk_add_sched: vector table plus arbitration, backpressure and reset sequences,
// with a response scoreboard fed by the driver and drained by a monitor.

module tb_bk_add_sched;

  localparam int unsigned W     = 128;
  localparam int unsigned CHUNK = 32;
  localparam int unsigned BEATS = W / CHUNK;
  localparam int          NV    = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
  logic [W-1:0] rsp_sum;

  always #5 clk = ~clk;

  bk_add_sched #(.W(W), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  exp_t        sb[$];
  int unsigned acc_cyc[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          acc_total = 0;
  vec_t        vecs[NV];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference arithmetic: sub gives A-B with cout = no borrow; add gives A+B+cin.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W:0] r;
    if (sub) r = {((a >= b) ? 1'b1 : 1'b0), a - b};
    else     r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: handshake rules, latency and scoreboard drain, sampled on the falling edge.
  initial begin
    logic prev_valid, prev_r0, prev_r1;
    int unsigned lat;
    exp_t e;
    prev_valid = 1'b0;
    prev_r0    = 1'b0;
    prev_r1    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        acc_cyc.delete();
        prev_valid = 1'b0;
        prev_r0    = 1'b0;
        prev_r1    = 1'b0;
      end else begin
        if (req0_ready || req1_ready) begin
          chk("ready_onehot", W'(req0_ready & req1_ready), '0);
          chk("ready_pulse", W'((req0_ready & prev_r0) | (req1_ready & prev_r1)), '0);
          chk("ready_while_busy", W'(busy), '0);
          acc_cyc.push_back(cyc);
          acc_total++;
        end
        if (rsp_valid && !prev_valid) begin
          if (acc_cyc.size() == 0) flag("rsp_valid_without_accept");
          else begin
            lat = cyc - acc_cyc.pop_front();
            chk("latency", W'(lat), W'(BEATS + 1));
          end
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) flag("rsp_unexpected");
          else begin
            e = sb.pop_front();
            chk("rsp_sum", rsp_sum, e.sum);
            chk("rsp_cout", W'(rsp_cout), W'(e.cout));
            chk("rsp_id", W'(rsp_id), W'(e.id));
          end
        end
        prev_valid = rsp_valid;
        prev_r0    = req0_ready;
        prev_r1    = req1_ready;
      end
    end
  end

  task automatic drive_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
    if (id == 1'b0) begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_valid = 1'b1;
    end
  endtask

  task automatic push_exp(input logic id, input logic [W-1:0] s, input logic c);
    exp_t e;
    e.id = id; e.sum = s; e.cout = c;
    sb.push_back(e);
  endtask

  // Issue one op from a requester; returns at posedge+1 just after the accept edge.
  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic [W-1:0] es, input logic ec);
    bit got;
    push_exp(id, es, ec);
    drive_req(id, a, b, cin, sub);
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) flag("grant_timeout");
    @(posedge clk);
    #1;
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !busy) return;
    end
    flag("drain_timeout");
  endtask

  initial begin
    logic [W:0] m;
    int         n;
    int         base;

    vecs[0] = '{1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
                128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0};
    vecs[1] = '{1'b1, ~128'd0, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1};
    vecs[2] = '{1'b1, ~128'd0, ~128'd0, 1'b1, 1'b0, ~128'd0, 1'b1};
    vecs[3] = '{1'b0, 128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1};
    vecs[4] = '{1'b0, 128'd5, 128'd7, 1'b0, 1'b1, ~128'd1, 1'b0};
    vecs[5] = '{1'b1, {32'd0, {96{1'b1}}}, 128'd1, 1'b0, 1'b0, 128'd1 << 96, 1'b0};
    vecs[6] = '{1'b0, 128'd0, 128'd0, 1'b0, 1'b1, 128'd0, 1'b1};
    vecs[7] = '{1'b1, 128'd1 << 127, 128'd1 << 127, 1'b0, 1'b0, 128'd0, 1'b1};
    for (int i = 8; i < NV; i++) begin
      vecs[i].id  = 1'($urandom_range(0, 1));
      vecs[i].a   = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].b   = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].cin = 1'($urandom_range(0, 1));
      vecs[i].sub = 1'(i % 2);
      m = model(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      vecs[i].exp_sum  = m[W-1:0];
      vecs[i].exp_cout = m[W];
    end

    // Reset values, with both requesters pushing during reset.
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", W'(req0_ready), '0);
    chk("rst_req1_ready", W'(req1_ready), '0);
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_rsp_sum", rsp_sum, '0);
    chk("rst_rsp_cout", W'(rsp_cout), '0);
    chk("rst_rsp_id", W'(rsp_id), '0);
    @(posedge clk);
    #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    // Arbitration: both valid continuously, expect ids 0,1,0,1.
    push_exp(1'b0, 128'd3, 1'b0);
    push_exp(1'b1, 128'd15, 1'b1);
    push_exp(1'b0, 128'd3, 1'b0);
    push_exp(1'b1, 128'd15, 1'b1);
    drive_req(1'b0, 128'd1, 128'd2, 1'b0, 1'b0);
    drive_req(1'b1, 128'd20, 128'd5, 1'b0, 1'b1);
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) n++;
    end
    if (n < 4) flag("arb_accept_timeout");
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_empty();

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].exp_sum, vecs[i].exp_cout);
      wait_empty();
    end

    // Requester drops valid before being granted: no grant.
    base = acc_total;
    do_op(1'b0, 128'd100, 128'd23, 1'b1, 1'b0, 128'd124, 1'b0);
    drive_req(1'b1, 128'd9, 128'd9, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_empty();
    chk("dropped_req_not_granted", W'(acc_total - base), W'(1));

    // Backpressure in DONE with a pending request from requester 1.
    rsp_ready = 1'b0;
    do_op(1'b0, 128'd10, 128'd20, 1'b0, 1'b0, 128'd30, 1'b0);
    push_exp(1'b1, 128'd101, 1'b0);
    drive_req(1'b1, 128'd100, 128'd1, 1'b0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) flag("bp_rsp_timeout");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", W'(rsp_valid), W'(1));
      chk("bp_rsp_sum", rsp_sum, 128'd30);
      chk("bp_rsp_cout", W'(rsp_cout), '0);
      chk("bp_rsp_id", W'(rsp_id), '0);
      chk("bp_req_ready", W'(req0_ready | req1_ready), '0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_valid_cleared", W'(rsp_valid), '0);
    chk("bp_next_accept", W'(req1_ready), W'(1));
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_empty();

    // Reset during beat 2 abandons the op; a fresh op then completes normally.
    do_op(1'b1, ~128'd0, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_rsp_valid", W'(rsp_valid), '0);
    chk("midrst_rsp_sum", rsp_sum, '0);
    repeat (8) @(posedge clk);
    #1;
    do_op(1'b0, 128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0);
    wait_empty();
    chk("sb_empty_at_end", W'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
